// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling
// and a single-entry valid/ready holding register.
module uart_receiver #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       gclk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_receiver: CLK_HZ/BAUD must round to at least 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Synchronizer resets to the idle level so reset release cannot look like a start bit.
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end

                START: begin
                    if (baud_cnt == CNT_HALF) begin
                        baud_cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        shreg    <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                            // A same-cycle transfer frees the holding register for the new byte.
                            if (!valid || ready) begin
                                data  <= shreg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLK_HZ=16, BAUD=1 (16 clocks per bit).
module tb_uart_receiver;

    localparam int DIV = 16;

    logic       gclk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b0;
    logic       frame_err;
    logic       overrun;

    uart_receiver #(.CLK_HZ(16), .BAUD(1)) dut (
        .gclk      (gclk),
        .rstn      (rstn),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 gclk = ~gclk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge gclk) cyc++;

    // Output monitor, sampled on the falling edge
    int         n_vcyc = 0;
    int         n_ferr = 0;
    int         n_ovr  = 0;
    int         rise_cyc = -1;
    logic [7:0] xq[$];
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_rstn  = 1'b0;
    logic [7:0] prev_data  = '0;

    always @(negedge gclk) begin
        if (valid) n_vcyc++;
        if (valid && ready) xq.push_back(data);
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (valid && !prev_valid) rise_cyc = cyc;
        if (rstn && prev_rstn && prev_valid && !prev_ready) begin
            n_cmp++;
            if (data !== prev_data) begin
                n_fail++;
                $display("FAIL data_hold: got %02h expected %02h", data, prev_data);
            end
        end
        prev_valid = valid;
        prev_ready = ready;
        prev_rstn  = rstn;
        prev_data  = data;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge gclk);
            #1;
        end
    endtask

    task automatic clr();
        n_vcyc   = 0;
        n_ferr   = 0;
        n_ovr    = 0;
        rise_cyc = -1;
        xq.delete();
    endtask

    // Start bit, 8 data bits LSB first, stop bit; a stop of 0 is held for low_tail more cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int low_tail);
        tick(1);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(DIV);
        end
        rx = stop;
        tick(DIV + low_tail);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         exp_x;
        logic [7:0] exp_d;
        int         exp_fe;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int start_cyc;
        int lat;

        vecs[0] = '{b: 8'hA5, stop: 1'b1, exp_x: 1, exp_d: 8'hA5, exp_fe: 0};
        vecs[1] = '{b: 8'h00, stop: 1'b1, exp_x: 1, exp_d: 8'h00, exp_fe: 0};
        vecs[2] = '{b: 8'hFF, stop: 1'b1, exp_x: 1, exp_d: 8'hFF, exp_fe: 0};
        vecs[3] = '{b: 8'h5A, stop: 1'b1, exp_x: 1, exp_d: 8'h5A, exp_fe: 0};
        vecs[4] = '{b: 8'h80, stop: 1'b1, exp_x: 1, exp_d: 8'h80, exp_fe: 0};
        vecs[5] = '{b: 8'h01, stop: 1'b1, exp_x: 1, exp_d: 8'h01, exp_fe: 0};
        vecs[6] = '{b: 8'h3C, stop: 1'b0, exp_x: 0, exp_d: 8'h01, exp_fe: 1};

        // Reset state
        tick(3);
        check("rst_data", int'(data), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_ovr", int'(overrun), 0);
        rstn = 1'b1;
        tick(5);
        check("post_rst_valid", int'(valid), 0);

        // Table: frames received with ready held high
        ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            clr();
            send_frame(vecs[i].b, vecs[i].stop, 0);
            tick(20);
            check($sformatf("v%0d_valid_cycles", i), n_vcyc, vecs[i].exp_x);
            check($sformatf("v%0d_xfers", i), xq.size(), vecs[i].exp_x);
            if (xq.size() > 0) check($sformatf("v%0d_xfer_data", i), int'(xq[0]), int'(vecs[i].b));
            check($sformatf("v%0d_ferr", i), n_ferr, vecs[i].exp_fe);
            check($sformatf("v%0d_ovr", i), n_ovr, 0);
            check($sformatf("v%0d_data", i), int'(data), int'(vecs[i].exp_d));
            check($sformatf("v%0d_valid_end", i), int'(valid), 0);
        end

        // Latency from start edge to valid
        clr();
        start_cyc = cyc + 1;
        send_frame(8'hA5, 1'b1, 0);
        tick(20);
        lat = rise_cyc - start_cyc - 1;
        n_cmp++;
        if (lat < 153 || lat > 155) begin
            n_fail++;
            $display("FAIL latency: got %0d expected 154 +/-1", lat);
        end
        check("lat_valid_cycles", n_vcyc, 1);
        check("lat_data", (xq.size() > 0) ? int'(xq[0]) : -1, 'hA5);

        // Short low glitch in IDLE
        clr();
        tick(1);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        check("glitch_valid", n_vcyc, 0);
        check("glitch_ferr", n_ferr, 0);
        check("glitch_ovr", n_ovr, 0);

        // Bad stop followed by a long break, then a good frame
        clr();
        send_frame(8'h3C, 1'b0, 100);
        tick(20);
        check("break_ferr", n_ferr, 1);
        check("break_valid", n_vcyc, 0);
        send_frame(8'h01, 1'b1, 0);
        tick(20);
        check("after_break_xfers", xq.size(), 1);
        check("after_break_data", (xq.size() > 0) ? int'(xq[0]) : -1, 'h01);
        check("after_break_ferr", n_ferr, 1);

        // Overrun with ready low
        clr();
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        tick(10);
        check("ovr_first_valid", int'(valid), 1);
        check("ovr_first_data", int'(data), 'h11);
        send_frame(8'h22, 1'b1, 0);
        tick(10);
        check("ovr_pulse", n_ovr, 1);
        check("ovr_data_held", int'(data), 'h11);
        check("ovr_valid_held", int'(valid), 1);
        check("ovr_no_xfer", xq.size(), 0);
        ready = 1'b1;
        tick(3);
        ready = 1'b0;
        check("ovr_drain_xfers", xq.size(), 1);
        check("ovr_drain_data", (xq.size() > 0) ? int'(xq[0]) : -1, 'h11);
        check("ovr_drain_valid", int'(valid), 0);

        // Transfer and completion in the same cycle
        clr();
        send_frame(8'h66, 1'b1, 0);
        tick(10);
        check("sim_hold_66", int'(data), 'h66);
        fork
            send_frame(8'h77, 1'b1, 0);
            begin
                tick(1);
                tick(154);
                ready = 1'b1;
                @(negedge gclk);
                check("sim_pre_valid", int'(valid), 1);
                check("sim_pre_data", int'(data), 'h66);
                tick(1);
                ready = 1'b0;
                @(negedge gclk);
                check("sim_post_valid", int'(valid), 1);
                check("sim_post_data", int'(data), 'h77);
            end
        join
        tick(5);
        check("sim_ovr", n_ovr, 0);
        check("sim_xfers", xq.size(), 1);
        check("sim_xfer_data", (xq.size() > 0) ? int'(xq[0]) : -1, 'h66);
        check("sim_valid_still", int'(valid), 1);
        ready = 1'b1;
        tick(3);
        check("sim_drain", xq.size(), 2);
        check("sim_drain_valid", int'(valid), 0);

        // Reset during data bit 4
        clr();
        tick(1);
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            tick(DIV);
        end
        rx = 1'b1;
        tick(8);
        #2;
        rstn = 1'b0;
        #1;
        check("midrst_data", int'(data), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_ferr", int'(frame_err), 0);
        check("midrst_ovr", int'(overrun), 0);
        rx = 1'b1;
        tick(3);
        rstn = 1'b1;
        tick(200);
        check("midrst_no_byte", n_vcyc, 0);
        check("midrst_no_ferr", n_ferr, 0);
        send_frame(8'hC3, 1'b1, 0);
        tick(20);
        check("midrst_next_xfers", xq.size(), 1);
        check("midrst_next_data", (xq.size() > 0) ? int'(xq[0]) : -1, 'hC3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, meaning the gclk frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 115_200, meaning the serial bit rate.
REQ-003 The block SHALL derive DIV = round(CLK_HZ/BAUD), which is 868 at the defaults, and HALF = DIV/2 (floor); it SHALL reject DIV < 4 at elaboration.
REQ-004 The block SHALL have port gclk, input, width 1: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rstn, input, width 1: reset, asynchronous and active-low.
REQ-006 The block SHALL have port rx, input, width 1: the asynchronous serial line, idle high, 8N1 framing (driven from the board uart_tx pin).
REQ-007 The block SHALL have port data, output, width 8: the received byte, valid while valid=1.
REQ-008 The block SHALL have port valid, output, width 1: high while a byte is held for the consumer.
REQ-009 The block SHALL have port ready, input, width 1: consumer accept; a transfer occurs on a cycle where valid=1 and ready=1.
REQ-010 The block SHALL have port frame_err, output, width 1: one-cycle pulse when a received stop bit is 0.
REQ-011 The block SHALL have port overrun, output, width 1: one-cycle pulse when a good byte is dropped because the holding register is full.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions SHALL use rx_s only.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP, and WAIT_HIGH.
REQ-014 In IDLE, rx_s=0 SHALL move the FSM to START and clear the baud counter.
REQ-015 In START, at baud count HALF-1: rx_s=0 SHALL move the FSM to DATA with bit index 0 and counter cleared; rx_s=1 (glitch) SHALL return the FSM to IDLE with no output.
REQ-016 In DATA, rx_s SHALL be sampled at each baud count DIV-1 and shifted LSB-first; after the 8th sample the FSM SHALL move to STOP.
REQ-017 In STOP, at baud count DIV-1: rx_s=1 SHALL complete the byte and return the FSM to IDLE; rx_s=0 SHALL pulse frame_err, discard the byte, and move the FSM to WAIT_HIGH.
REQ-018 WAIT_HIGH SHALL stay until rx_s=1, then go to IDLE, so that a break condition yields exactly one frame_err.
REQ-019 On byte completion with valid=0, or with valid=1 and ready=1 in the same cycle, data SHALL load and valid SHALL be 1 on the next cycle.
REQ-020 On byte completion with valid=1 and ready=0, overrun SHALL pulse, the new byte SHALL be dropped, and data SHALL hold its old value.
REQ-021 On a transfer with no simultaneous completion, valid SHALL fall on the next cycle; data SHALL hold its last value.
REQ-022 data SHALL NOT change while valid=1 and ready=0.
REQ-023 The latency from the rx stop-bit sample point to valid high SHALL be 1 cycle; the total latency from the start-bit falling edge is 2 + HALF + 9*DIV cycles ±1.
REQ-024 The baud counter SHALL wrap from DIV-1 to 0 and SHALL be no wider than clog2(DIV).
REQ-025 ready SHALL have no effect while valid=0.

Reset
REQ-026 rstn=0 SHALL immediately, asynchronously, drive state to IDLE, counters to 0, shift register to 0, data to 8'h00, and valid, frame_err, and overrun to 0.
REQ-027 The synchronizer flops SHALL reset to 1 (line idle) so that deassertion never produces a false start.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for rx_s=1 then 0 before starting a new frame, and no partial byte SHALL be emitted.

Verification (CLK_HZ=16, BAUD=1: DIV=16, HALF=8)
REQ-029 The bench SHALL send 8'hA5 with a good stop and ready=1 -> the response SHALL be valid for exactly 1 cycle with data=8'hA5, 2+8+144 (±1) cycles after the start edge, and frame_err=overrun=0.
REQ-030 The bench SHALL drive a 4-cycle low glitch on rx in IDLE -> the FSM SHALL return to IDLE with no valid, frame_err, or overrun.
REQ-031 The bench SHALL send 8'h3C with a stop bit of 0, then hold rx=0 for 100 cycles -> the response SHALL be exactly one frame_err pulse and valid=0, and the next good frame 8'h01 SHALL be received correctly.
REQ-032 The bench SHALL send 8'h11 then 8'h22 with ready=0 -> the response SHALL be data=8'h11 held, valid=1, and one overrun pulse at the second stop; raising ready SHALL give a transfer of 8'h11, then valid=0.
REQ-033 The bench SHALL hold ready=1 on the stop-sample cycle of 8'h77 while valid=1 with 8'h66 -> the response SHALL be a transfer of 8'h66 and a next-cycle load of data=8'h77 with valid=1, and no overrun.
REQ-034 The bench SHALL assert rstn=0 during the data bit 4 of a frame, then release it -> the response SHALL be outputs at reset values immediately and no byte emitted, and the next full frame 8'hC3 SHALL be received correctly.
